// File: rtl/instr_cmd_sequencer.sv
// Command FIFO + issue sequencer between the host memory wrapper and
// the 16-bit core.
// Ports:
//   cmd_*   : valid/ready instruction input into a DEPTH-entry FIFO.
//   proc_*  : one-cycle issue strobe and instruction to the core,
//             core registers a/b/c sampled PROC_LAT cycles later.
//   rsp_*   : valid/ready result channel (regs a/b/c plus tag).
//   busy, queue_level : status.
// Optional: define SEQ_CMD_COUNT_EN to add cmd_count, a 16-bit
// counter of completed response handshakes.
module instr_cmd_sequencer #(
  parameter int DEPTH    = 4,
  parameter int PROC_LAT = 3,
  parameter int TAG_W    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [15:0]                cmd_instr,
  output logic                       proc_do_instruction,
  output logic [15:0]                proc_instruction,
  input  logic [15:0]                proc_reg_a,
  input  logic [15:0]                proc_reg_b,
  input  logic [15:0]                proc_reg_c,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [15:0]                rsp_reg_a,
  output logic [15:0]                rsp_reg_b,
  output logic [15:0]                rsp_reg_c,
  output logic [TAG_W-1:0]           rsp_tag,
  output logic                       busy,
`ifdef SEQ_CMD_COUNT_EN
  output logic [15:0]                cmd_count,
`endif
  output logic [$clog2(DEPTH+1)-1:0] queue_level
);

  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = (PROC_LAT > 1) ? $clog2(PROC_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  state_e             state_q, state_d;
  logic [15:0]        mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [TAG_W-1:0]   tag_lat_q, tag_lat_d;
  logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        last_q, last_d;
  logic [15:0]        a_q, a_d;
  logic [15:0]        b_q, b_d;
  logic [15:0]        c_q, c_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               push, pop, hs;
  logic [15:0]        head;

  // Ready comes from the registered level only: a full FIFO does not
  // accept a word even in the cycle it pops.
  assign cmd_ready = (level_q != LVL_W'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == ISSUE);
  assign hs        = rsp_valid_q && rsp_ready;
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop) level_d = level_q + LVL_W'(1);
    if (!push && pop) level_d = level_q - LVL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd_instr;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tag_d       = tag_q;
    tag_lat_d   = tag_lat_q;
    last_d      = last_q;
    rsp_valid_d = rsp_valid_q;
    rsp_tag_d   = rsp_tag_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    unique case (state_q)
      IDLE: begin
        if (level_q != '0) state_d = ISSUE;
      end
      ISSUE: begin
        last_d    = head;
        tag_lat_d = tag_q;
        tag_d     = tag_q + TAG_W'(1);
        cnt_d     = CNT_W'(PROC_LAT - 1);
        state_d   = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          a_d         = proc_reg_a;
          b_d         = proc_reg_b;
          c_d         = proc_reg_c;
          rsp_tag_d   = tag_lat_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (hs) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      tag_q       <= '0;
      tag_lat_q   <= '0;
      rsp_tag_q   <= '0;
      cnt_q       <= '0;
      last_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      tag_q       <= tag_d;
      tag_lat_q   <= tag_lat_d;
      rsp_tag_q   <= rsp_tag_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

`ifdef SEQ_CMD_COUNT_EN
  logic [15:0] cmd_count_q, cmd_count_d;

  always_comb begin
    cmd_count_d = cmd_count_q;
    if (hs) cmd_count_d = cmd_count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cmd_count_q <= '0;
    else       cmd_count_q <= cmd_count_d;
  end

  assign cmd_count = cmd_count_q;
`endif

  // The instruction bus shows the FIFO head while issuing and
  // otherwise holds the last issued word.
  assign proc_do_instruction = pop;
  assign proc_instruction    = pop ? head : last_q;
  assign rsp_valid           = rsp_valid_q;
  assign rsp_reg_a           = a_q;
  assign rsp_reg_b           = b_q;
  assign rsp_reg_c           = c_q;
  assign rsp_tag             = rsp_tag_q;
  assign busy                = (state_q != IDLE);
  assign queue_level         = level_q;

endmodule

// File: tb/tb_instr_cmd_sequencer.sv
// Self-checking bench for instr_cmd_sequencer: directed scenarios
// plus randomized traffic against a queue-based reference model.
module tb_instr_cmd_sequencer;

  localparam int DEPTH    = 4;
  localparam int PROC_LAT = 3;
  localparam int TAG_W    = 4;
  localparam int LVL_W    = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [15:0]       cmd_instr = '0;
  logic              proc_do_instruction;
  logic [15:0]       proc_instruction;
  logic [15:0]       proc_reg_a = '0;
  logic [15:0]       proc_reg_b = '0;
  logic [15:0]       proc_reg_c = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [15:0]       rsp_reg_a;
  logic [15:0]       rsp_reg_b;
  logic [15:0]       rsp_reg_c;
  logic [TAG_W-1:0]  rsp_tag;
  logic              busy;
  logic [LVL_W-1:0]  queue_level;
`ifdef SEQ_CMD_COUNT_EN
  logic [15:0]       cmd_count;
`endif

  always #5 clk = ~clk;

  instr_cmd_sequencer #(
    .DEPTH(DEPTH), .PROC_LAT(PROC_LAT), .TAG_W(TAG_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_instr(cmd_instr),
    .proc_do_instruction(proc_do_instruction),
    .proc_instruction(proc_instruction),
    .proc_reg_a(proc_reg_a),
    .proc_reg_b(proc_reg_b),
    .proc_reg_c(proc_reg_c),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_reg_a(rsp_reg_a),
    .rsp_reg_b(rsp_reg_b),
    .rsp_reg_c(rsp_reg_c),
    .rsp_tag(rsp_tag),
    .busy(busy),
`ifdef SEQ_CMD_COUNT_EN
    .cmd_count(cmd_count),
`endif
    .queue_level(queue_level)
  );

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [31:0] got,
                              logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endfunction

  // Reference model. ph is the age of the command in hand:
  // -1 none, 0 issue cycle, 1..PROC_LAT executing,
  // PROC_LAT+1 result offered to the host.
  logic [15:0]      mq[$];
  int               ph = -1;
  logic [15:0]      m_last = '0;
  logic [15:0]      m_a = '0, m_b = '0, m_c = '0;
  logic [TAG_W-1:0] m_tag = '0, m_cur = '0, m_rtag = '0;
  bit               m_rv = 1'b0;
  int               m_count = 0;
  bit               m_push;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      ph      = -1;
      m_last  = '0;
      m_a     = '0;
      m_b     = '0;
      m_c     = '0;
      m_tag   = '0;
      m_cur   = '0;
      m_rtag  = '0;
      m_rv    = 1'b0;
      m_count = 0;
    end else begin
      m_push = cmd_valid && (mq.size() != DEPTH);
      if (ph == -1) begin
        if (mq.size() > 0) ph = 0;
      end else if (ph == 0) begin
        m_last = mq.pop_front();
        m_cur  = m_tag;
        m_tag  = m_tag + 1'b1;
        ph     = 1;
      end else if (ph <= PROC_LAT) begin
        if (ph == PROC_LAT) begin
          m_a    = proc_reg_a;
          m_b    = proc_reg_b;
          m_c    = proc_reg_c;
          m_rtag = m_cur;
          m_rv   = 1'b1;
        end
        ph++;
      end else if (rsp_ready) begin
        m_rv = 1'b0;
        ph   = -1;
        m_count++;
      end
      if (m_push) mq.push_back(cmd_instr);
    end
  end

  logic [TAG_W-1:0] seen_tag[$];
  logic [15:0]      seen_instr[$];

  always @(negedge clk) begin
    if (!reset) begin
      chk("cmd_ready", cmd_ready, mq.size() != DEPTH);
      chk("queue_level", queue_level, mq.size());
      chk("busy", busy, ph != -1);
      chk("do_instr", proc_do_instruction, ph == 0);
      chk("proc_instr", proc_instruction, (ph == 0) ? mq[0] : m_last);
      chk("rsp_valid", rsp_valid, m_rv);
      chk("rsp_a", rsp_reg_a, m_a);
      chk("rsp_b", rsp_reg_b, m_b);
      chk("rsp_c", rsp_reg_c, m_c);
      chk("rsp_tag", rsp_tag, m_rtag);
`ifdef SEQ_CMD_COUNT_EN
      chk("cmd_count", cmd_count, m_count);
`endif
      if (proc_do_instruction) seen_instr.push_back(proc_instruction);
      if (rsp_valid && rsp_ready) seen_tag.push_back(rsp_tag);
    end
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_ready"}, cmd_ready, 1);
    chk({tag, "_do"}, proc_do_instruction, 0);
    chk({tag, "_instr"}, proc_instruction, 0);
    chk({tag, "_rv"}, rsp_valid, 0);
    chk({tag, "_a"}, rsp_reg_a, 0);
    chk({tag, "_tag"}, rsp_tag, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_lvl"}, queue_level, 0);
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    reset     = 1'b1;
    #1;
    chk_reset_vals("rst");
    cyc(1);
    reset = 1'b0;
    seen_tag.delete();
    seen_instr.delete();
  endtask

  task automatic wait_rsp(int n, int budget);
    int k;
    k = 0;
    while (seen_tag.size() < n && k < budget) begin
      cyc(1);
      k++;
    end
    chk("drain_count", seen_tag.size(), n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int rvs;
    #3;
    do_reset();

    // single command, fixed register values
    proc_reg_a = 16'hAAAA;
    proc_reg_b = 16'hBBBB;
    proc_reg_c = 16'hCCCC;
    rsp_ready  = 1'b1;
    cmd_valid  = 1'b1;
    cmd_instr  = 16'h1234;
    cyc(1);
    cmd_valid = 1'b0;
    chk("t1_lvl", queue_level, 1);
    cyc(1);
    chk("t1_do", proc_do_instruction, 1);
    chk("t1_instr", proc_instruction, 16'h1234);
    cyc(1);
    chk("t1_do_off", proc_do_instruction, 0);
    cyc(2);
    chk("t1_rv_early", rsp_valid, 0);
    cyc(1);
    chk("t1_rv", rsp_valid, 1);
    chk("t1_a", rsp_reg_a, 16'hAAAA);
    chk("t1_b", rsp_reg_b, 16'hBBBB);
    chk("t1_c", rsp_reg_c, 16'hCCCC);
    chk("t1_tag", rsp_tag, 0);
    cyc(1);
    chk("t1_rv_drop", rsp_valid, 0);
    chk("t1_idle", busy, 0);
    chk("t1_hold_instr", proc_instruction, 16'h1234);

    // fill with the host stalled, then hold in RESP
    do_reset();
    rsp_ready = 1'b0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cmd_instr = 16'h0100 + 16'(i);
      cyc(1);
      if (i == 3) chk("t2_lvl3", queue_level, 3);
    end
    cmd_valid = 1'b0;
    chk("t2_lvl4", queue_level, 4);
    chk("t2_full", cmd_ready, 0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      pulses += int'(proc_do_instruction);
    end
    chk("t2_no_issue", pulses, 0);
    chk("t2_rv_hold", rsp_valid, 1);
    chk("t2_tag_hold", rsp_tag, 0);
    rsp_ready = 1'b1;
    wait_rsp(5, 200);
    for (int i = 0; i < 5; i++) begin
      if (i < seen_tag.size()) chk("t2_tag_ord", seen_tag[i], i);
      if (i < seen_instr.size())
        chk("t2_instr_ord", seen_instr[i], 32'h100 + i);
    end
    chk("t2_issues", seen_instr.size(), 5);

    // tag wrap over 17 commands
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      cmd_instr = 16'h0200 + 16'(i);
      cmd_valid = 1'b1;
      cyc(1);
      cmd_valid = 1'b0;
      wait_rsp(i + 1, 40);
    end
    if (seen_tag.size() == 17) begin
      chk("t3_tag15", seen_tag[15], 15);
      chk("t3_tag16", seen_tag[16], 0);
    end
`ifdef SEQ_CMD_COUNT_EN
    cyc(1);
    chk("t3_count", cmd_count, 17);
`endif

    // reset while executing with two commands queued
    do_reset();
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cmd_instr = 16'h0300 + 16'(i);
      cyc(1);
    end
    cmd_valid = 1'b0;
    chk("t4_lvl", queue_level, 2);
    chk("t4_busy", busy, 1);
    chk("t4_wait", proc_do_instruction, 0);
    #1;
    reset = 1'b1;
    #1;
    chk_reset_vals("t4_async");
    @(posedge clk);
    #2;
    reset = 1'b0;
    rvs = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      rvs += int'(rsp_valid);
    end
    chk("t4_no_rsp", rvs, 0);
    chk("t4_lvl0", queue_level, 0);

    // push while popping at level 2
    do_reset();
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cmd_instr = 16'h0400 + 16'(i);
      cyc(1);
    end
    cmd_valid = 1'b0;
    chk("t5_lvl", queue_level, 2);
    wait_rsp(3, 60);
    for (int i = 0; i < 3; i++)
      if (i < seen_instr.size())
        chk("t5_order", seen_instr[i], 32'h400 + i);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cmd_valid  = ($urandom_range(0, 99) < 45);
      cmd_instr  = 16'($urandom);
      rsp_ready  = ($urandom_range(0, 99) < 65);
      proc_reg_a = 16'($urandom);
      proc_reg_b = 16'($urandom);
      proc_reg_c = 16'($urandom);
      cyc(1);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    cyc(60);
    chk("rand_lvl0", queue_level, 0);
    chk("rand_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
